// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
//  Shared definitions for the fetch stage: FSM state encoding, the default
//  reset vector, the per-word PC increment and the all-zero word that stops
//  fetching.
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0800;
    localparam int          PC_STEP_DEF      = 4;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
//  Bundles the three buses around the fetch stage:
//   - program memory : RD, WR, BusDirecciones (out), BusDatos (in)
//   - decoder handoff: IR_Data, IR_PC, IR_Valid (out), IR_Ready (in)
//   - redirect/status: BR_Valid, BR_Target (in), Halted (out)
//  master = fetch stage, slave = memory/decoder/branch side.
// ---------------------------------------------------------------------------
interface instruction_fetch_if #(
    parameter int DW = 32
);
    logic          RD;
    logic          WR;
    logic [DW-1:0] BusDirecciones;
    logic [DW-1:0] BusDatos;
    logic [DW-1:0] IR_Data;
    logic [DW-1:0] IR_PC;
    logic          IR_Valid;
    logic          IR_Ready;
    logic          BR_Valid;
    logic [DW-1:0] BR_Target;
    logic          Halted;

    modport master (
        output RD, WR, BusDirecciones, IR_Data, IR_PC, IR_Valid, Halted,
        input  BusDatos, IR_Ready, BR_Valid, BR_Target
    );

    modport slave (
        input  RD, WR, BusDirecciones, IR_Data, IR_PC, IR_Valid, Halted,
        output BusDatos, IR_Ready, BR_Valid, BR_Target
    );
endinterface : instruction_fetch_if

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//  Initiator of the program-memory read bus. Owns the PC, reads one word per
//  cycle from a combinational memory into a 1-entry instruction register and
//  hands it to the decoder with a valid/ready handshake. Supports branch
//  redirect and halting on an all-zero word.
// Ports
//  CLOCK_50    in  single clock, rising edge
//  RESET_InLow in  asynchronous active-low reset
//  bus         master modport of instruction_fetch_if (memory, IR, branch,
//              Halted)
// ---------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                     DATAWIDTH_BUS = 32,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_VECTOR  = DATAWIDTH_BUS'(RESET_VECTOR_DEF),
    parameter int                     PC_STEP       = PC_STEP_DEF,
    parameter bit                     HALT_ON_ZERO  = 1'b1
) (
    input  logic               CLOCK_50,
    input  logic               RESET_InLow,
    instruction_fetch_if.master bus
);

    localparam int DW = DATAWIDTH_BUS;

    fetch_state_e  state_q, state_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_data_q, ir_data_d;
    logic [DW-1:0] ir_pc_q, ir_pc_d;
    logic          ir_valid_q, ir_valid_d;

    logic take;
    logic consume;
    logic zero_word;

    // A read happens only when the IR slot is free (or being emptied this
    // edge) and no redirect is pending; a redirect burns the cycle.
    assign take      = (state_q == FETCH) && (!ir_valid_q || bus.IR_Ready) && !bus.BR_Valid;
    assign consume   = ir_valid_q && bus.IR_Ready;
    assign zero_word = HALT_ON_ZERO && (bus.BusDatos == DW'(NOP_WORD));

    // Registers reset to FETCH/empty, which would otherwise make take=1 while
    // the reset is still held, so the strobe is gated by reset directly.
    assign bus.RD             = take && RESET_InLow;
    assign bus.WR             = 1'b0;
    assign bus.BusDirecciones = bus.RD ? pc_q : '0;
    assign bus.IR_Data        = ir_data_q;
    assign bus.IR_PC          = ir_pc_q;
    assign bus.IR_Valid       = ir_valid_q;
    assign bus.Halted         = (state_q == HALT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;

        if (bus.BR_Valid) begin
            // Redirect flushes the IR even if the decoder is taking it now.
            pc_d       = {bus.BR_Target[DW-1:2], 2'b00};
            ir_valid_d = 1'b0;
            state_d    = FETCH;
        end else if (take) begin
            if (zero_word) begin
                // take implies the old IR was empty or consumed this edge,
                // so the slot ends up empty; PC stays on the zero word.
                ir_valid_d = 1'b0;
                state_d    = HALT;
            end else begin
                ir_data_d  = bus.BusDatos;
                ir_pc_d    = pc_q;
                ir_valid_d = 1'b1;
                pc_d       = pc_q + DW'(PC_STEP);
            end
        end else if (consume) begin
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            state_q    <= FETCH;
            pc_q       <= RESET_VECTOR;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic CLOCK_50 = 1'b0;
    logic RESET_InLow;
    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    instruction_fetch_if #(.DW(32)) bus ();

    instruction_fetch dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_InLow (RESET_InLow),
        .bus         (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // ROM image: 0x800 holds a real instruction, 0x838 is the halting zero
    // word, everything else is a nonzero address-tagged pattern.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0000_0800)      return 32'h8280_2001;
        else if (a == 32'h0000_0838) return 32'h0000_0000;
        else                         return {16'hA5A5, a[15:0]};
    endfunction

    assign bus.BusDatos = rom(bus.BusDirecciones);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    // Expect a word from pc to be captured on the next edge.
    task automatic fetch_step(input logic [31:0] pc);
        exp_t e;
        sb_q.push_back('{pc: pc, data: rom(pc)});
        tick();
        e = sb_q.pop_front();
        chk("ir_valid", 32'(bus.IR_Valid), 32'd1);
        chk("ir_pc",    bus.IR_PC,   e.pc);
        chk("ir_data",  bus.IR_Data, e.data);
    endtask

    initial begin
        RESET_InLow   = 1'b0;
        bus.IR_Ready  = 1'b1;
        bus.BR_Valid  = 1'b0;
        bus.BR_Target = '0;

        // T1 reset
        repeat (3) tick();
        chk("rst_rd",     32'(bus.RD), 32'd0);
        chk("rst_wr",     32'(bus.WR), 32'd0);
        chk("rst_addr",   bus.BusDirecciones, 32'h0);
        chk("rst_valid",  32'(bus.IR_Valid), 32'd0);
        chk("rst_halted", 32'(bus.Halted), 32'd0);
        RESET_InLow = 1'b1;
        #1;
        chk("t1_rd",   32'(bus.RD), 32'd1);
        chk("t1_addr", bus.BusDirecciones, 32'h800);

        // T2 streaming
        fetch_step(32'h800);
        fetch_step(32'h804);
        fetch_step(32'h808);

        // T3 backpressure
        bus.IR_Ready = 1'b0;
        #1;
        chk("t3_rd_stall", 32'(bus.RD), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_rd",    32'(bus.RD), 32'd0);
            chk("t3_addr",  bus.BusDirecciones, 32'h0);
            chk("t3_valid", 32'(bus.IR_Valid), 32'd1);
            chk("t3_irpc",  bus.IR_PC, 32'h808);
            chk("t3_irdat", bus.IR_Data, rom(32'h808));
        end
        bus.IR_Ready = 1'b1;
        #1;
        chk("t3_resume_addr", bus.BusDirecciones, 32'h80C);
        fetch_step(32'h80C);

        // T4 branch while IR valid and consumed
        bus.BR_Valid  = 1'b1;
        bus.BR_Target = 32'h813;
        #1;
        chk("t4_rd_br", 32'(bus.RD), 32'd0);
        tick();
        bus.BR_Valid = 1'b0;
        chk("t4_flush", 32'(bus.IR_Valid), 32'd0);
        #1;
        chk("t4_addr", bus.BusDirecciones, 32'h810);
        fetch_step(32'h810);

        // T5 halt on zero word at 0x838
        for (int a = 32'h814; a <= 32'h834; a += 4) fetch_step(32'(a));
        tick();
        chk("t5_halted", 32'(bus.Halted), 32'd1);
        chk("t5_valid",  32'(bus.IR_Valid), 32'd0);
        chk("t5_irpc",   bus.IR_PC, 32'h834);
        chk("t5_rd",     32'(bus.RD), 32'd0);
        chk("t5_pc",     dut.pc_q, 32'h838);
        repeat (2) tick();
        chk("t5_halted2", 32'(bus.Halted), 32'd1);
        chk("t5_addr2",   bus.BusDirecciones, 32'h0);
        chk("t5_pc2",     dut.pc_q, 32'h838);
        bus.BR_Valid  = 1'b1;
        bus.BR_Target = 32'h800;
        tick();
        bus.BR_Valid = 1'b0;
        chk("t5_unhalt", 32'(bus.Halted), 32'd0);
        #1;
        chk("t5_resume_addr", bus.BusDirecciones, 32'h800);
        fetch_step(32'h800);

        // T6 async reset between edges
        #2;
        RESET_InLow = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.IR_Valid), 32'd0);
        chk("t6_rd",    32'(bus.RD), 32'd0);
        chk("t6_pc",    dut.pc_q, 32'h800);
        tick();
        RESET_InLow = 1'b1;
        #1;
        chk("t6_addr", bus.BusDirecciones, 32'h800);

        // PC wrap
        bus.BR_Valid  = 1'b1;
        bus.BR_Target = 32'hFFFF_FFFC;
        tick();
        bus.BR_Valid = 1'b0;
        #1;
        chk("wrap_addr0", bus.BusDirecciones, 32'hFFFF_FFFC);
        fetch_step(32'hFFFF_FFFC);
        #1;
        chk("wrap_addr1", bus.BusDirecciones, 32'h0);
        fetch_step(32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instruction_fetch
